dcache_ctrl: RTL and testbench
==============================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL provide a single clock and a synchronous, active-high reset: clk_i, rst_i.
REQ-002 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 cpu_MemRead_i  in  1  CPU load request from the MEM stage.
REQ-005 cpu_MemWrite_i  in  1  CPU store request from the MEM stage.
REQ-006 cpu_addr_i  in  32  byte address, word-aligned.
REQ-007 cpu_data_i  in  32  store data.
REQ-008 cpu_data_o  out  32  load data, valid when cpu_stall_o=0.
REQ-009 cpu_stall_o  out  1  freezes all pipeline registers, including MEM_WB via its cpu_stall_i.
REQ-010 mem_enable_o  out  1  memory request, held high until mem_ack_i.
REQ-011 mem_write_o  out  1  1=line write-back, 0=line fill.
REQ-012 mem_addr_o  out  32  line address, bits [4:0]=0.
REQ-013 mem_data_o  out  256  write-back line data.
REQ-014 mem_data_i  in  256  fill line data, valid with mem_ack_i.
REQ-015 mem_ack_i  in  1  one-cycle completion pulse from data memory.

Function
REQ-016 SHALL implement a direct-mapped, write-back, write-allocate cache of 16 lines x 32 bytes.
REQ-017 Address split SHALL be: tag=[31:9] (23b), index=[8:5], word offset=[4:2]; bits [1:0] ignored.
REQ-018 Each line SHALL hold valid, dirty, a 23b tag and 256b data.
REQ-019 hit SHALL equal (valid & tag match) for the indexed line; req = MemRead | MemWrite.
REQ-020 cpu_stall_o SHALL be combinational: req & ~hit, or state != IDLE; it SHALL be high in the same cycle a miss request appears.
REQ-021 Read hit: cpu_data_o SHALL present the addressed word combinationally, with zero stall cycles.
REQ-022 Write hit: at the clock edge, the SHALL update the addressed word and set dirty=1; no stall.
REQ-023 If MemRead and MemWrite are both high, the request SHALL be treated as a write.
REQ-024 FSM states SHALL be IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
REQ-025 IDLE->MISS on req & ~hit; otherwise stay in IDLE.
REQ-026 MISS->WRITEBACK if the victim is valid & dirty; otherwise MISS->READMISS.
REQ-027 WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line; ->READMISS on mem_ack_i.
REQ-028 READMISS: mem_enable_o=1, mem_write_o=0, mem_addr_o={req tag, index, 5'b0}; on mem_ack_i, write mem_data_i into the line (valid=1, dirty=0, new tag) and ->READMISSOK.
REQ-029 READMISSOK->IDLE unconditionally; the request then hits and completes as in REQ-021/022.
REQ-030 mem_enable_o SHALL be 0 in IDLE, MISS and READMISSOK.
REQ-031 The CPU request SHALL be held stable while stalled; the controller SHALL NOT latch it.
REQ-032 A mem_ack_i in IDLE, MISS or READMISSOK SHALL be ignored.

Reset
REQ-033 rst_i SHALL force state=IDLE and clear all valid and dirty bits; tag and data contents are don't-care.
REQ-034 After reset all outputs SHALL be 0 (cpu_stall_o=0 when req=0).
REQ-035 Reset during WRITEBACK or READMISS SHALL drop mem_enable_o on the next edge and abandon the transfer; it SHALL NOT write to the arrays.

Structure
REQ-036 The shared package SHALL hold the FSM state enum, the line/tag/index widths and the line count.
REQ-037 The tag/data storage SHALL be one sub-module, dcache_sram (16 entries, combinational read, synchronous write, valid/dirty reset).

Verification
REQ-038 Cold read of 0x0000_0040 -> stall high; IDLE,MISS,READMISS; fill with ack after 10 cycles; READMISSOK; hit; data = word 0 of the fill; stall lasts 14 cycles.
REQ-039 Read hit of 0x0000_0044 after REQ-038 -> zero stall; cpu_data_o = fill word 1.
REQ-040 Write 0xDEADBEEF to 0x0000_0040, then read 0x0000_0240 (same index) -> WRITEBACK to mem_addr 0x0000_0040 with mem_data_o[31:0]=0xDEADBEEF, then a fill from 0x0000_0240.
REQ-041 Clean-victim miss -> MISS goes directly to READMISS; no write-back is issued.
REQ-042 rst_i pulsed in READMISS -> next cycle state=IDLE, mem_enable_o=0; a later read of the same address misses again.
REQ-043 MemRead and MemWrite both high on a hit -> the word is written and dirty=1.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// rtl/dcache_ctrl_pkg.sv - shared widths, line count and FSM state encoding for the data cache
package dcache_ctrl_pkg;

    localparam int NUM_LINES = 16;
    localparam int INDEX_W   = 4;
    localparam int TAG_W     = 23;
    localparam int OFFSET_W  = 3;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = 256;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MISS       = 3'd1,
        WRITEBACK  = 3'd2,
        READMISS   = 3'd3,
        READMISSOK = 3'd4
    } state_t;

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - 16-entry tag/data store, combinational read, synchronous write
module dcache_sram
    import dcache_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [INDEX_W-1:0] i_index,
    input  logic               i_we,
    input  logic               i_wr_dirty,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [LINE_W-1:0]  i_wr_data,
    output logic               o_valid,
    output logic               o_dirty,
    output logic [TAG_W-1:0]   o_tag,
    output logic [LINE_W-1:0]  o_data
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];

    // Status bits are the only state cleared by reset; any write marks the line valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= i_wr_dirty;
        end
    end

    // Tag and data arrays carry no reset; a write during reset is suppressed.
    always_ff @(posedge i_clk) begin
        if (i_we && !i_rst) begin
            r_tag[i_index]  <= i_wr_tag;
            r_data[i_index] <= i_wr_data;
        end
    end

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_data  = r_data[i_index];

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    state_t r_state;
    state_t w_state_nxt;

    logic                w_req;
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic [7:0]          w_bit_pos;
    logic                w_unused_addr_bits;

    logic                w_line_valid;
    logic                w_line_dirty;
    logic [TAG_W-1:0]    w_line_tag;
    logic [LINE_W-1:0]   w_line_data;
    logic                w_hit;

    logic                w_wr_hit;
    logic                w_fill;
    logic                w_we;
    logic                w_wr_dirty;
    logic [LINE_W-1:0]   w_wr_data;
    logic [LINE_W-1:0]   w_merged;

    assign w_req              = cpu_MemRead_i | cpu_MemWrite_i;
    assign w_tag              = cpu_addr_i[31:9];
    assign w_index            = cpu_addr_i[8:5];
    assign w_offset           = cpu_addr_i[4:2];
    assign w_bit_pos          = {w_offset, 5'b0};
    assign w_unused_addr_bits = ^cpu_addr_i[1:0];

    assign w_hit       = w_line_valid && (w_line_tag == w_tag);
    assign cpu_stall_o = (w_req && !w_hit) || (r_state != IDLE);
    assign cpu_data_o  = w_hit ? w_line_data[w_bit_pos +: WORD_W] : '0;

    // A store only commits from IDLE, so it lands after any fill has completed.
    assign w_wr_hit   = (r_state == IDLE) && cpu_MemWrite_i && w_hit;
    assign w_fill     = (r_state == READMISS) && mem_ack_i;
    assign w_we       = (w_wr_hit || w_fill) && !rst_i;
    assign w_wr_dirty = !w_fill;
    assign w_wr_data  = w_fill ? mem_data_i : w_merged;

    // Current line with the addressed word replaced by the store data.
    always_comb begin
        w_merged = w_line_data;
        w_merged[w_bit_pos +: WORD_W] = cpu_data_i;
    end

    dcache_sram u_sram (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_index    (w_index),
        .i_we       (w_we),
        .i_wr_dirty (w_wr_dirty),
        .i_wr_tag   (w_tag),
        .i_wr_data  (w_wr_data),
        .o_valid    (w_line_valid),
        .o_dirty    (w_line_dirty),
        .o_tag      (w_line_tag),
        .o_data     (w_line_data)
    );

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and memory-side outputs; the request is read live, never latched.
    always_comb begin
        w_state_nxt  = r_state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (r_state)
            IDLE: begin
                if (w_req && !w_hit) begin
                    w_state_nxt = MISS;
                end
            end
            MISS: begin
                if (w_line_valid && w_line_dirty) begin
                    w_state_nxt = WRITEBACK;
                end else begin
                    w_state_nxt = READMISS;
                end
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {w_line_tag, w_index, 5'b0};
                mem_data_o   = w_line_data;
                if (mem_ack_i) begin
                    w_state_nxt = READMISS;
                end
            end
            READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {w_tag, w_index, 5'b0};
                if (mem_ack_i) begin
                    w_state_nxt = READMISSOK;
                end
            end
            READMISSOK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl with reference model and scoreboards
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    dcache_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [31:0]  exp_rdata;
        int           exp_stall;
        logic         has_wb;
        logic [31:0]  wb_addr;
        logic [255:0] wb_data;
        logic         has_fill;
        logic [31:0]  fill_addr;
    } vec_t;

    typedef struct {
        logic         is_wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } memop_t;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        int          stall;
    } resp_t;

    memop_t memq[$];
    resp_t  respq[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     rcnt  = 0;

    logic [31:0]  ref_mem [logic [31:0]];
    logic [255:0] bk_mem  [logic [31:0]];
    logic         m_valid [16];
    logic         m_dirty [16];
    logic [22:0]  m_tag   [16];

    localparam int MISS_CLEAN = 14;
    localparam int MISS_DIRTY = 25;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return ref_mem.exists(k) ? ref_mem[k] : pat(k);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_rd(la + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [255:0] bk_line(input logic [31:0] la);
        logic [255:0] l;
        if (bk_mem.exists(la)) return bk_mem[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat(la + 32'(w * 4));
        return l;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
    endtask

    // Reference model: predicts stall length, memory traffic and load data.
    task automatic model_req(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output vec_t v);
        int          idx;
        logic [22:0] tg;
        idx = int'(addr[8:5]);
        tg  = addr[31:9];
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = '0; v.exp_stall = 0;
        v.has_wb = 1'b0; v.wb_addr = '0; v.wb_data = '0;
        v.has_fill = 1'b0; v.fill_addr = '0;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                v.has_wb    = 1'b1;
                v.wb_addr   = {m_tag[idx], addr[8:5], 5'b0};
                v.wb_data   = ref_line(v.wb_addr);
                v.exp_stall = MISS_DIRTY;
            end else begin
                v.exp_stall = MISS_CLEAN;
            end
            v.has_fill  = 1'b1;
            v.fill_addr = {addr[31:5], 5'b0};
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        if (wr) begin
            ref_mem[{addr[31:2], 2'b00}] = wdata;
            m_dirty[idx] = 1'b1;
        end else begin
            v.exp_rdata = ref_rd(addr);
        end
    endtask

    task automatic apply(input vec_t v);
        resp_t r;
        int    cyc;
        if (v.has_wb)   memq.push_back('{1'b1, v.wb_addr, v.wb_data});
        if (v.has_fill) memq.push_back('{1'b0, v.fill_addr, 256'b0});
        respq.push_back('{v.rd & ~v.wr, v.exp_rdata, v.exp_stall});
        @(negedge clk_i);
        cpu_MemRead_i  = v.rd;
        cpu_MemWrite_i = v.wr;
        cpu_addr_i     = v.addr;
        cpu_data_i     = v.wdata;
        #1;
        cyc = 0;
        while (cpu_stall_o && cyc < 100) begin
            @(negedge clk_i);
            #1;
            cyc++;
        end
        r = respq.pop_front();
        check($sformatf("stall_cycles@%0h", v.addr), 256'(cyc), 256'(r.stall));
        if (r.is_read) check($sformatf("rdata@%0h", v.addr), 256'(cpu_data_o), 256'(r.data));
        @(posedge clk_i);
        #1;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    task automatic run(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        vec_t v;
        model_req(rd, wr, addr, wdata, v);
        apply(v);
    endtask

    // Memory responder: acks on the 11th cycle of a request and checks it against the queue.
    always @(negedge clk_i) begin
        memop_t op;
        mem_ack_i = 1'b0;
        if (mem_enable_o) begin
            if (rcnt == 10) begin
                rcnt      = 0;
                mem_ack_i = 1'b1;
                if (memq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_memop: got write=%0b addr=%0h expected none", mem_write_o, mem_addr_o);
                end else begin
                    op = memq.pop_front();
                    check("memop_write", 256'(mem_write_o), 256'(op.is_wr));
                    check("memop_addr", 256'(mem_addr_o), 256'(op.addr));
                    if (op.is_wr) check("wb_data", mem_data_o, op.data);
                end
                if (mem_write_o) bk_mem[mem_addr_o] = mem_data_o;
                else             mem_data_i = bk_line(mem_addr_o);
            end else begin
                rcnt++;
            end
        end else begin
            rcnt = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    vec_t tbl [24];

    initial begin
        int          cyc;
        logic [31:0] a;
        int          op;
        rst_i = 1'b1;
        cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
        cpu_addr_i = '0; cpu_data_i = '0;
        mem_data_i = '0; mem_ack_i = 1'b0;
        model_clear();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_stall", 256'(cpu_stall_o), 256'(0));
        check("rst_cpu_data", 256'(cpu_data_o), 256'(0));
        check("rst_mem_enable", 256'(mem_enable_o), 256'(0));
        check("rst_mem_write", 256'(mem_write_o), 256'(0));
        check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        check("rst_mem_data", mem_data_o, 256'(0));

        run(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        run(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        run(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        run(1'b1, 1'b0, 32'h0000_0240, 32'h0);
        run(1'b1, 1'b0, 32'h0000_0440, 32'h0);
        run(1'b1, 1'b1, 32'h0000_0444, 32'h1234_5678);
        run(1'b1, 1'b0, 32'h0000_0444, 32'h0);
        run(1'b1, 1'b0, 32'h0000_0040, 32'h0);

        @(negedge clk_i);
        cpu_MemRead_i = 1'b1;
        cpu_addr_i    = 32'h0000_0840;
        cyc = 0;
        while (!(mem_enable_o && !mem_write_o) && cyc < 20) begin
            @(negedge clk_i);
            cyc++;
        end
        check("reach_readmiss", 256'(cyc < 20), 256'(1));
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        cpu_MemRead_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_readmiss_enable", 256'(mem_enable_o), 256'(0));
        check("rst_readmiss_stall", 256'(cpu_stall_o), 256'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        model_clear();
        run(1'b1, 1'b0, 32'h0000_0840, 32'h0);

        for (int i = 0; i < 24; i++) begin
            a  = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
            op = $urandom_range(0, 3);
            model_req(op == 3 || op < 2, op >= 2, a, $urandom, tbl[i]);
        end
        for (int i = 0; i < 24; i++) apply(tbl[i]);

        repeat (3) @(negedge clk_i);
        check("memq_drained", 256'(memq.size()), 256'(0));
        check("respq_drained", 256'(respq.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
